// File: rtl/ysyx_22050710_axi_pkg.sv
// Shared AXI4 definitions: burst/response codes, size encoding and the
// cache-bridge state encoding.
package ysyx_22050710_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WADDR = 3'd3,
    ST_WRESP = 3'd4,
    ST_DONE  = 3'd5
  } bridge_state_e;

  // AxSIZE encoding for a beat of nbytes bytes (nbytes a power of two up to 128)
  function automatic logic [2:0] axi_size(input int unsigned nbytes);
    logic [2:0] size_v;
    size_v = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((32'd1 << i) == nbytes) begin
        size_v = 3'(i);
      end else begin
        size_v = size_v;
      end
    end
    return size_v;
  endfunction

endpackage

// File: rtl/ysyx_22050710_axi_line_collector.sv
// Read-beat collector: beat counter, line buffer and rlast/rresp checking.
module ysyx_22050710_axi_line_collector
  import ysyx_22050710_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int LINE_BEATS = 2,
  parameter int CNT_W      = $clog2(LINE_BEATS) + 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             r_fire,
  input  logic [DATA_WIDTH-1:0]            rdata,
  input  logic [1:0]                       rresp,
  input  logic                             rlast,
  input  logic [CNT_W-1:0]                 last_idx,
  output logic [LINE_BEATS*DATA_WIDTH-1:0] line_data,
  output logic                             final_beat,
  output logic                             beat_err
);

  localparam int IDX_W = $clog2(LINE_BEATS);

  logic [CNT_W-1:0]                 beat_cnt_r;
  logic [LINE_BEATS*DATA_WIDTH-1:0] line_r;
  logic                             is_last_s;

  assign is_last_s  = (beat_cnt_r == last_idx);
  assign final_beat = r_fire && is_last_s;
  // rlast must coincide exactly with the beat the bridge expects to be final
  assign beat_err   = r_fire && ((rresp != RESP_OKAY) || (rlast != is_last_s));
  assign line_data  = line_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_r <= '0;
      line_r     <= '0;
    end else if (clear) begin
      beat_cnt_r <= '0;
    end else if (r_fire && (beat_cnt_r < CNT_W'(LINE_BEATS))) begin
      line_r[beat_cnt_r[IDX_W-1:0]*DATA_WIDTH +: DATA_WIDTH] <= rdata;
      beat_cnt_r <= beat_cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ysyx_22050710_cache_axi4full_bridge.sv
// Cache/LSU request port to AXI4-full master: line refill, single read or
// single write, one transaction outstanding.
module ysyx_22050710_cache_axi4full_bridge
  import ysyx_22050710_axi_pkg::*;
#(
  parameter int         DATA_WIDTH = 64,
  parameter int         ADDR_WIDTH = 32,
  parameter int         STRB_WIDTH = DATA_WIDTH / 8,
  parameter int         LINE_BEATS = 2,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                             i_aclk,
  input  logic                             i_arsetn,
  input  logic                             i_req_valid,
  output logic                             o_req_ready,
  input  logic                             i_req_wen,
  input  logic                             i_req_line,
  input  logic [ADDR_WIDTH-1:0]            i_req_addr,
  input  logic [DATA_WIDTH-1:0]            i_req_wdata,
  input  logic [STRB_WIDTH-1:0]            i_req_wstrb,
  output logic                             o_resp_valid,
  output logic [LINE_BEATS*DATA_WIDTH-1:0] o_resp_rdata,
  output logic                             o_resp_err,
  output logic [3:0]                       o_awid,
  output logic [ADDR_WIDTH-1:0]            o_awaddr,
  output logic [7:0]                       o_awlen,
  output logic [2:0]                       o_awsize,
  output logic [1:0]                       o_awburst,
  output logic                             o_awlock,
  output logic [3:0]                       o_awcache,
  output logic [2:0]                       o_awprot,
  output logic                             o_awvalid,
  input  logic                             i_awready,
  output logic [3:0]                       o_wid,
  output logic [DATA_WIDTH-1:0]            o_wdata,
  output logic [STRB_WIDTH-1:0]            o_wstrb,
  output logic                             o_wlast,
  output logic                             o_wvalid,
  input  logic                             i_wready,
  input  logic [3:0]                       i_bid,
  input  logic [1:0]                       i_bresp,
  input  logic                             i_bvalid,
  output logic                             o_bready,
  output logic [3:0]                       o_arid,
  output logic [ADDR_WIDTH-1:0]            o_araddr,
  output logic [7:0]                       o_arlen,
  output logic [2:0]                       o_arsize,
  output logic [1:0]                       o_arburst,
  output logic                             o_arlock,
  output logic [3:0]                       o_arcache,
  output logic [2:0]                       o_arprot,
  output logic                             o_arvalid,
  input  logic                             i_arready,
  input  logic [3:0]                       i_rid,
  input  logic [DATA_WIDTH-1:0]            i_rdata,
  input  logic [1:0]                       i_rresp,
  input  logic                             i_rlast,
  input  logic                             i_rvalid,
  output logic                             o_rready
);

  localparam int         BEAT_OFF  = $clog2(STRB_WIDTH);
  localparam int         LINE_OFF  = $clog2(LINE_BEATS * STRB_WIDTH);
  localparam int         CNT_W     = $clog2(LINE_BEATS) + 1;
  localparam logic [2:0] BEAT_SIZE = axi_size(STRB_WIDTH);

  bridge_state_e                  state_r;
  bridge_state_e                  state_s;
  logic                           line_r;
  logic [ADDR_WIDTH-1:BEAT_OFF]   addr_r;
  logic [DATA_WIDTH-1:0]          wdata_r;
  logic [STRB_WIDTH-1:0]          wstrb_r;
  logic                           err_r;
  logic                           aw_done_r;
  logic                           w_done_r;
  logic                           req_fire_s;
  logic                           ar_fire_s;
  logic                           r_fire_s;
  logic                           aw_fire_s;
  logic                           w_fire_s;
  logic                           b_fire_s;
  logic                           final_beat_s;
  logic                           beat_err_s;
  logic [CNT_W-1:0]               last_idx_s;
  logic [ADDR_WIDTH-1:0]          araddr_s;
  logic [7:0]                     arlen_s;
  logic                           unused_s;

  assign unused_s = ^{i_bid, i_rid, i_req_addr[BEAT_OFF-1:0]};

  assign req_fire_s = i_req_valid && o_req_ready;
  assign ar_fire_s  = o_arvalid && i_arready;
  assign r_fire_s   = o_rready && i_rvalid;
  assign aw_fire_s  = o_awvalid && i_awready;
  assign w_fire_s   = o_wvalid && i_wready;
  assign b_fire_s   = o_bready && i_bvalid;

  // State register
  always_ff @(posedge i_aclk or negedge i_arsetn) begin
    if (!i_arsetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_req_valid) begin
          state_s = i_req_wen ? ST_WADDR : ST_RADDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RADDR: begin
        if (ar_fire_s) state_s = ST_RDATA;
        else           state_s = ST_RADDR;
      end
      ST_RDATA: begin
        if (final_beat_s) state_s = ST_DONE;
        else              state_s = ST_RDATA;
      end
      ST_WADDR: begin
        if ((aw_done_r || aw_fire_s) && (w_done_r || w_fire_s)) state_s = ST_WRESP;
        else                                                    state_s = ST_WADDR;
      end
      ST_WRESP: begin
        if (b_fire_s) state_s = ST_DONE;
        else          state_s = ST_WRESP;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Request capture, AW/W completion flags and error accumulation
  always_ff @(posedge i_aclk or negedge i_arsetn) begin
    if (!i_arsetn) begin
      line_r    <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
      wstrb_r   <= '0;
      err_r     <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else if (req_fire_s) begin
      line_r    <= i_req_line;
      addr_r    <= i_req_addr[ADDR_WIDTH-1:BEAT_OFF];
      wdata_r   <= i_req_wdata;
      wstrb_r   <= i_req_wstrb;
      err_r     <= 1'b0;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      if (aw_fire_s) aw_done_r <= 1'b1;
      if (w_fire_s)  w_done_r  <= 1'b1;
      if (beat_err_s || (b_fire_s && (i_bresp != RESP_OKAY))) err_r <= 1'b1;
    end
  end

  // Read address/length: line refills align to the line, single reads to the beat
  always_comb begin
    araddr_s   = {addr_r, {BEAT_OFF{1'b0}}};
    arlen_s    = 8'd0;
    last_idx_s = '0;
    if (line_r) begin
      araddr_s[LINE_OFF-1:0] = '0;
      arlen_s                = 8'(LINE_BEATS - 1);
      last_idx_s             = CNT_W'(LINE_BEATS - 1);
    end else begin
      araddr_s[LINE_OFF-1:0] = araddr_s[LINE_OFF-1:0];
    end
  end

  ysyx_22050710_axi_line_collector #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_BEATS (LINE_BEATS),
    .CNT_W      (CNT_W)
  ) u_collector (
    .clk        (i_aclk),
    .rst_n      (i_arsetn),
    .clear      (req_fire_s),
    .r_fire     (r_fire_s),
    .rdata      (i_rdata),
    .rresp      (i_rresp),
    .rlast      (i_rlast),
    .last_idx   (last_idx_s),
    .line_data  (o_resp_rdata),
    .final_beat (final_beat_s),
    .beat_err   (beat_err_s)
  );

  assign o_req_ready  = (state_r == ST_IDLE);
  assign o_resp_valid = (state_r == ST_DONE);
  assign o_resp_err   = err_r;

  assign o_arid    = AXI_ID;
  assign o_araddr  = araddr_s;
  assign o_arlen   = arlen_s;
  assign o_arsize  = BEAT_SIZE;
  assign o_arburst = BURST_INCR;
  assign o_arlock  = 1'b0;
  assign o_arcache = 4'd0;
  assign o_arprot  = 3'd0;
  assign o_arvalid = (state_r == ST_RADDR);
  assign o_rready  = (state_r == ST_RDATA);

  assign o_awid    = AXI_ID;
  assign o_awaddr  = {addr_r, {BEAT_OFF{1'b0}}};
  assign o_awlen   = 8'd0;
  assign o_awsize  = BEAT_SIZE;
  assign o_awburst = BURST_INCR;
  assign o_awlock  = 1'b0;
  assign o_awcache = 4'd0;
  assign o_awprot  = 3'd0;
  assign o_awvalid = (state_r == ST_WADDR) && !aw_done_r;

  assign o_wid     = AXI_ID;
  assign o_wdata   = wdata_r;
  assign o_wstrb   = wstrb_r;
  assign o_wlast   = 1'b1;
  assign o_wvalid  = (state_r == ST_WADDR) && !w_done_r;
  assign o_bready  = (state_r == ST_WRESP);

endmodule

// File: tb/tb_ysyx_22050710_cache_axi4full_bridge.sv
// Directed bench for the cache AXI4-full bridge with a small SRAM-like slave model.
module tb_ysyx_22050710_cache_axi4full_bridge;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req_valid = 1'b0, req_ready, req_wen = 1'b0, req_line = 1'b0;
  logic [31:0]  req_addr = 32'd0;
  logic [63:0]  req_wdata = 64'd0;
  logic [7:0]   req_wstrb = 8'd0;
  logic         resp_valid, resp_err;
  logic [127:0] resp_rdata;
  logic [3:0]   awid, wid, arid;
  logic [31:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, awprot, arsize, arprot;
  logic [1:0]   awburst, arburst;
  logic         awlock, arlock, awvalid, wvalid, wlast, bready, arvalid, rready;
  logic [3:0]   awcache, arcache;
  logic [63:0]  wdata;
  logic [7:0]   wstrb;
  logic         awready, wready, bvalid, arready, rvalid, rlast;
  logic [1:0]   bresp, rresp;
  logic [63:0]  rdata;

  ysyx_22050710_cache_axi4full_bridge dut (
    .i_aclk(clk), .i_arsetn(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wen(req_wen),
    .i_req_line(req_line), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .i_req_wstrb(req_wstrb), .o_resp_valid(resp_valid), .o_resp_rdata(resp_rdata),
    .o_resp_err(resp_err),
    .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen), .o_awsize(awsize),
    .o_awburst(awburst), .o_awlock(awlock), .o_awcache(awcache), .o_awprot(awprot),
    .o_awvalid(awvalid), .i_awready(awready),
    .o_wid(wid), .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast),
    .o_wvalid(wvalid), .i_wready(wready),
    .i_bid(4'd0), .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
    .o_arid(arid), .o_araddr(araddr), .o_arlen(arlen), .o_arsize(arsize),
    .o_arburst(arburst), .o_arlock(arlock), .o_arcache(arcache), .o_arprot(arprot),
    .o_arvalid(arvalid), .i_arready(arready),
    .i_rid(4'd0), .i_rdata(rdata), .i_rresp(rresp), .i_rlast(rlast),
    .i_rvalid(rvalid), .o_rready(rready)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model state and knobs
  logic [63:0] mem [0:63];
  int          mode = 0;        // 0 SRAM-like, 1 W first / AW stalled, 2 AW+W together
  int          err_beat = -1;
  logic        early_last = 1'b0;
  logic        ar_f, r_f, aw_f, w_f, b_f;
  logic [31:0] cap_araddr, cap_awaddr;
  logic [7:0]  cap_arlen;
  logic [2:0]  cap_arsize;
  logic [1:0]  cap_arburst;
  logic [63:0] cap_wdata;
  logic [7:0]  cap_wstrb;
  logic        cap_wlast;
  int          n_ar = 0, n_aw = 0, n_w = 0, n_b = 0, n_resp = 0;
  logic        rd_busy, aw_got, w_got;
  int          s_beat, s_len, stall;
  logic [5:0]  s_base;

  // handshake sampling at the active edge (pre-update values)
  always @(posedge clk) begin
    ar_f = arvalid && arready;
    r_f  = rvalid && rready;
    aw_f = awvalid && awready;
    w_f  = wvalid && wready;
    b_f  = bvalid && bready;
    if (ar_f) begin
      cap_araddr = araddr; cap_arlen = arlen; cap_arsize = arsize; cap_arburst = arburst; n_ar++;
    end
    if (aw_f) begin cap_awaddr = awaddr; n_aw++; end
    if (w_f) begin cap_wdata = wdata; cap_wstrb = wstrb; cap_wlast = wlast; n_w++; end
    if (b_f) n_b++;
  end

  // slave reaction on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_busy = 1'b0; aw_got = 1'b0; w_got = 1'b0; stall = 0; s_beat = 0; s_len = 0; s_base = 6'd0;
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = 64'd0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    end else begin
      if (ar_f) begin
        rd_busy = 1'b1; s_beat = 0; s_len = int'(cap_arlen); s_base = cap_araddr[8:3];
      end else if (r_f) begin
        if (s_beat == s_len) rd_busy = 1'b0;
        else s_beat++;
      end
      arready = !rd_busy;
      rvalid  = rd_busy;
      rdata   = rd_busy ? mem[6'(s_base + 6'(s_beat))] : 64'd0;
      rlast   = rd_busy && (early_last ? (s_beat == 0) : (s_beat == s_len));
      rresp   = (rd_busy && s_beat == err_beat) ? 2'b10 : 2'b00;
      if (aw_f) aw_got = 1'b1;
      if (w_f)  w_got  = 1'b1;
      if (b_f) begin
        bvalid = 1'b0; aw_got = 1'b0; w_got = 1'b0; stall = 0;
      end else if (aw_got && w_got && !bvalid) begin
        for (int b = 0; b < 8; b++)
          if (cap_wstrb[b]) mem[cap_awaddr[8:3]][b*8 +: 8] = cap_wdata[b*8 +: 8];
        bvalid = 1'b1; bresp = 2'b00;
      end
      case (mode)
        1: begin
          if (awvalid && stall < 3) stall++;
          awready = (stall >= 3); wready = 1'b1;
        end
        2: begin awready = 1'b1; wready = 1'b1; end
        default: begin awready = !aw_got; wready = aw_got && !w_got; end
      endcase
    end
  end

  always @(negedge clk) if (resp_valid) n_resp++;

  // One request; lat counts cycles from the accepting cycle to resp_valid
  task automatic do_req(input logic wen, input logic line, input logic [31:0] addr,
                        input logic [63:0] wd, input logic [7:0] ws,
                        output int lat, output logic err, output logic [127:0] rd);
    int r0;
    lat = 0; err = 1'bx; rd = 'x; r0 = n_resp;
    @(posedge clk); #1;
    chk_eq("req_ready_before", req_ready, 1'b1);
    req_valid = 1'b1; req_wen = wen; req_line = line; req_addr = addr;
    req_wdata = wd; req_wstrb = ws;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin lat = c; err = resp_err; rd = resp_rdata; break; end
    end
    @(negedge clk);
    chk_eq("resp_pulse_drop", resp_valid, 1'b0);
    chk_eq("back_to_idle", req_ready, 1'b1);
    chk_eq("resp_pulse_count", 128'(n_resp - r0), 128'd1);
  endtask

  int          lat;
  logic        err;
  logic [127:0] rd;
  int          a0, w0, b0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 64'h0101_0101_0101_0101 * 64'(i);
    mem[0] = 64'h1122_3344_5566_7788;
    mem[2] = 64'hA0A1_A2A3_A4A5_A6A7;
    mem[3] = 64'hB0B1_B2B3_B4B5_B6B7;
    repeat (3) @(negedge clk);
    chk_eq("rst_req_ready", req_ready, 1'b1);
    chk_eq("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
    chk_eq("rst_resp", {resp_valid, resp_err}, 2'b0);
    chk_eq("rst_rdata", resp_rdata, 128'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // single read
    do_req(1'b0, 1'b0, 32'h8000_0004, 64'd0, 8'd0, lat, err, rd);
    chk_eq("sr_araddr", cap_araddr, 32'h8000_0000);
    chk_eq("sr_arlen", cap_arlen, 8'd0);
    chk_eq("sr_arsize", cap_arsize, 3'd3);
    chk_eq("sr_arburst", cap_arburst, 2'b01);
    chk_eq("sr_lat", lat, 3);
    chk_eq("sr_rdata", rd, {64'd0, 64'h1122_3344_5566_7788});
    chk_eq("sr_err", err, 1'b0);

    // line refill
    do_req(1'b0, 1'b1, 32'h8000_0018, 64'd0, 8'd0, lat, err, rd);
    chk_eq("lr_araddr", cap_araddr, 32'h8000_0010);
    chk_eq("lr_arlen", cap_arlen, 8'd1);
    chk_eq("lr_arsize", cap_arsize, 3'd3);
    chk_eq("lr_lat", lat, 4);
    chk_eq("lr_rdata", rd, {64'hB0B1_B2B3_B4B5_B6B7, 64'hA0A1_A2A3_A4A5_A6A7});
    chk_eq("lr_err", err, 1'b0);

    // write, SRAM-like ordering
    b0 = n_b;
    do_req(1'b1, 1'b0, 32'h8000_0020, 64'h0000_0000_DEAD_BEEF, 8'h0F, lat, err, rd);
    chk_eq("wr_awaddr", cap_awaddr, 32'h8000_0020);
    chk_eq("wr_wlast", cap_wlast, 1'b1);
    chk_eq("wr_lat", lat, 4);
    chk_eq("wr_err", err, 1'b0);
    chk_eq("wr_mem", mem[4], 64'h0404_0404_DEAD_BEEF);
    chk_eq("wr_rdata_kept", rd, {64'hB0B1_B2B3_B4B5_B6B7, 64'hA0A1_A2A3_A4A5_A6A7});
    chk_eq("wr_one_b", 128'(n_b - b0), 128'd1);

    // W first, AW stalled
    @(posedge clk); #1 mode = 1;
    a0 = n_aw; w0 = n_w; b0 = n_b;
    do_req(1'b1, 1'b0, 32'h8000_0028, 64'h0102_0304_0506_0708, 8'hFF, lat, err, rd);
    chk_eq("wf_lat", lat, 5);
    chk_eq("wf_one_aw", 128'(n_aw - a0), 128'd1);
    chk_eq("wf_one_w", 128'(n_w - w0), 128'd1);
    chk_eq("wf_one_b", 128'(n_b - b0), 128'd1);
    chk_eq("wf_mem", mem[5], 64'h0102_0304_0506_0708);

    // AW and W together
    @(posedge clk); #1 mode = 2;
    a0 = n_aw; w0 = n_w; b0 = n_b;
    do_req(1'b1, 1'b0, 32'h8000_0030, 64'h5555_AAAA_7777_8888, 8'hF0, lat, err, rd);
    chk_eq("sc_lat", lat, 3);
    chk_eq("sc_one_aw", 128'(n_aw - a0), 128'd1);
    chk_eq("sc_one_w", 128'(n_w - w0), 128'd1);
    chk_eq("sc_one_b", 128'(n_b - b0), 128'd1);
    chk_eq("sc_mem", mem[6], 64'h5555_AAAA_0606_0606);

    // SLVERR on beat 1 of a refill
    @(posedge clk); #1 mode = 0; err_beat = 1;
    do_req(1'b0, 1'b1, 32'h8000_0040, 64'd0, 8'd0, lat, err, rd);
    chk_eq("slverr_err", err, 1'b1);
    chk_eq("slverr_lat", lat, 4);
    chk_eq("slverr_rdata", rd, {64'h0909_0909_0909_0909, 64'h0808_0808_0808_0808});

    // rlast on beat 0 of a refill
    @(posedge clk); #1 err_beat = -1; early_last = 1'b1;
    do_req(1'b0, 1'b1, 32'h8000_0050, 64'd0, 8'd0, lat, err, rd);
    chk_eq("rlast_err", err, 1'b1);

    // clean single read afterwards: slot 1 keeps the previous line word
    @(posedge clk); #1 early_last = 1'b0;
    do_req(1'b0, 1'b0, 32'h8000_0058, 64'd0, 8'd0, lat, err, rd);
    chk_eq("post_err_clear", err, 1'b0);
    chk_eq("post_rdata", rd, {64'h0B0B_0B0B_0B0B_0B0B, 64'h0B0B_0B0B_0B0B_0B0B});

    // reset during RDATA
    @(posedge clk); #1;
    req_valid = 1'b1; req_wen = 1'b0; req_line = 1'b1; req_addr = 32'h8000_0000;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int c = 0; c < 20 && rready !== 1'b1; c++) @(negedge clk);
    chk_eq("rst_mid_in_rdata", rready, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk_eq("rst_mid_valids", {arvalid, awvalid, wvalid, rready, bready, resp_valid}, 6'b0);
    chk_eq("rst_mid_rdata", resp_rdata, 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_eq("rst_mid_ready", req_ready, 1'b1);
    do_req(1'b0, 1'b0, 32'h8000_0000, 64'd0, 8'd0, lat, err, rd);
    chk_eq("after_rst_lat", lat, 3);
    chk_eq("after_rst_rdata", rd, {64'd0, 64'h1122_3344_5566_7788});
    chk_eq("after_rst_err", err, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
